hw_to_sw_tx: RTL and testbench

- Hardware-to-software byte transmitter. It is the counterpart of the software-to-hardware record receiver.
- On a start pulse it reads NUM_RECORDS 24-bit records, one at a time, from a synchronous on-chip RAM. Each record is sent as 3 bytes, MSB first, over the 8-bit PIO data bus using the 2-bit to_sw_sig/to_hw_sig handshake.
- Used to return per-frame object state (positions, collision flags) to the NIOS software.

---
 rtl/hw_to_sw_tx_if.sv | 25 ++
 rtl/hw_to_sw_tx.sv | 139 +++++++++++++
 tb/tb_hw_to_sw_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hw_to_sw_tx_if.sv
// Handshake and record-RAM bus of the hardware-to-software byte transmitter.
// master = transmitter, slave = RAM / PIO / control side.
interface hw_to_sw_tx_if #(
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic [7:0]        to_sw_data;
  logic [1:0]        to_sw_sig;
  logic [1:0]        to_hw_sig;

  modport master (
    input  start, rd_data, to_hw_sig,
    output busy, done, rd_en, rd_addr, to_sw_data, to_sw_sig
  );

  modport slave (
    output start, rd_data, to_hw_sig,
    input  busy, done, rd_en, rd_addr, to_sw_data, to_sw_sig
  );
endinterface

// File: rtl/hw_to_sw_tx.sv
// Reads NUM_RECORDS 24-bit records from a synchronous RAM and streams them,
// MSB byte first, to software over the 2-bit to_sw_sig/to_hw_sig PIO handshake.
module hw_to_sw_tx #(
  parameter int NUM_RECORDS = 32,
  parameter int ADDR_W      = 5
) (
  input  logic          clk50,
  input  logic          reset,
  hw_to_sw_tx_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ARM      = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_LATCH    = 4'd3;
  localparam logic [3:0] S_SEND_HI  = 4'd4;
  localparam logic [3:0] S_ACK_HI   = 4'd5;
  localparam logic [3:0] S_SEND_MID = 4'd6;
  localparam logic [3:0] S_ACK_MID  = 4'd7;
  localparam logic [3:0] S_SEND_LO  = 4'd8;
  localparam logic [3:0] S_ACK_LO   = 4'd9;
  localparam logic [3:0] S_NEXT     = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

  localparam logic [1:0] SIG_WAIT  = 2'd0;
  localparam logic [1:0] SIG_VALID = 2'd1;
  localparam logic [1:0] SIG_END   = 2'd2;

  localparam logic [1:0] HW_READY = 2'd1;
  localparam logic [1:0] HW_TAKEN = 2'd2;
  localparam logic [1:0] HW_ENDAK = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_RECORDS - 1);

  logic [3:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        sig_q;
  logic [7:0]        data_q;
  logic [23:0]       rec_sr;

  // Every output is produced on the edge that enters the state it belongs to,
  // so all of them come straight from flops.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sig_q     <= SIG_WAIT;
      data_q    <= 8'h00;
      rec_sr    <= 24'h0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state  <= S_ARM;
          busy_q <= 1'b1;
          idx    <= '0;
        end
        S_ARM: if (bus.to_hw_sig == HW_READY) begin
          state     <= S_FETCH;
          rd_en_q   <= 1'b1;
          rd_addr_q <= idx;
        end
        S_FETCH: state <= S_LATCH;
        // rec_sr keeps the not-yet-sent bytes left-aligned
        S_LATCH: begin
          state  <= S_SEND_HI;
          sig_q  <= SIG_VALID;
          data_q <= bus.rd_data[23:16];
          rec_sr <= {bus.rd_data[15:0], 8'h00};
        end
        S_SEND_HI: if (bus.to_hw_sig == HW_TAKEN) begin
          state <= S_ACK_HI;
          sig_q <= SIG_WAIT;
        end
        S_SEND_MID: if (bus.to_hw_sig == HW_TAKEN) begin
          state <= S_ACK_MID;
          sig_q <= SIG_WAIT;
        end
        S_SEND_LO: if (bus.to_hw_sig == HW_TAKEN) begin
          state <= S_ACK_LO;
          sig_q <= SIG_WAIT;
        end
        S_ACK_HI: if (bus.to_hw_sig == HW_READY) begin
          state  <= S_SEND_MID;
          sig_q  <= SIG_VALID;
          data_q <= rec_sr[23:16];
          rec_sr <= {rec_sr[15:0], 8'h00};
        end
        S_ACK_MID: if (bus.to_hw_sig == HW_READY) begin
          state  <= S_SEND_LO;
          sig_q  <= SIG_VALID;
          data_q <= rec_sr[23:16];
          rec_sr <= {rec_sr[15:0], 8'h00};
        end
        S_ACK_LO: if (bus.to_hw_sig == HW_READY) state <= S_NEXT;
        // software is still at READY here, so the next fetch needs no re-arm
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            sig_q <= SIG_END;
          end else begin
            state     <= S_FETCH;
            idx       <= idx + ADDR_W'(1);
            rd_addr_q <= idx + ADDR_W'(1);
            rd_en_q   <= 1'b1;
          end
        end
        S_DONE: if (bus.to_hw_sig == HW_ENDAK) begin
          state  <= S_IDLE;
          sig_q  <= SIG_WAIT;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          sig_q  <= SIG_WAIT;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.to_sw_data = data_q;
  assign bus.to_sw_sig  = sig_q;

endmodule

// File: tb/tb_hw_to_sw_tx.sv
// Bench: a 2-record and a 32-record transmitter driven by a software-side
// handshake model; expected bytes are derived directly from the RAM contents.
module tb_hw_to_sw_tx;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] hw = 2'd0;
  logic sel = 1'b0;

  always #5 clk50 = ~clk50;

  hw_to_sw_tx_if #(.ADDR_W(1)) if_a ();
  hw_to_sw_tx_if #(.ADDR_W(5)) if_b ();

  hw_to_sw_tx #(.NUM_RECORDS(2), .ADDR_W(1)) dut_a (.clk50(clk50), .reset(reset), .bus(if_a));
  hw_to_sw_tx #(.NUM_RECORDS(32), .ADDR_W(5)) dut_b (.clk50(clk50), .reset(reset), .bus(if_b));

  assign if_a.start     = start && !sel;
  assign if_b.start     = start && sel;
  assign if_a.to_hw_sig = sel ? 2'd0 : hw;
  assign if_b.to_hw_sig = sel ? hw : 2'd0;

  logic [23:0] ram_a [0:1];
  logic [23:0] ram_b [0:31];

  always @(posedge clk50) if (if_a.rd_en) if_a.rd_data <= ram_a[if_a.rd_addr];
  always @(posedge clk50) if (if_b.rd_en) if_b.rd_data <= ram_b[if_b.rd_addr];

  logic       m_busy, m_done, m_rd_en;
  logic [4:0] m_addr;
  logic [7:0] m_data;
  logic [1:0] m_sig;

  always_comb begin
    m_busy  = sel ? if_b.busy       : if_a.busy;
    m_done  = sel ? if_b.done       : if_a.done;
    m_rd_en = sel ? if_b.rd_en      : if_a.rd_en;
    m_addr  = sel ? if_b.rd_addr    : 5'(if_a.rd_addr);
    m_data  = sel ? if_b.to_sw_data : if_a.to_sw_data;
    m_sig   = sel ? if_b.to_sw_sig  : if_a.to_sw_sig;
  end

  int checks = 0;
  int errs   = 0;
  int done_cnt = 0;
  int rd_log[$];
  logic [7:0] exp_q[$];

  always @(posedge clk50) begin
    if (m_rd_en === 1'b1) rd_log.push_back(int'(m_addr));
    if (m_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_sig(input logic [1:0] v, input string tag);
    int k = 0;
    while (m_sig !== v && k < 300) begin
      step();
      k++;
    end
    chk(tag, 32'(m_sig), 32'(v));
  endtask

  task automatic pause(input int dly);
    int d = (dly < 0) ? int'($urandom_range(3, 0)) : dly;
    repeat (d) step();
  endtask

  // Expected byte stream: every record contributes its three bytes, MSB first.
  task automatic build_exp(input int n);
    logic [23:0] r;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      r = sel ? ram_b[i] : ram_a[i];
      exp_q.push_back(r[23:16]);
      exp_q.push_back(r[15:8]);
      exp_q.push_back(r[7:0]);
    end
  endtask

  // Software side of one transfer. Hook arguments pick a byte index for a
  // long stall, illegal codes, a stray start, or an async reset (-1 = off).
  task automatic run_xfer(input int n, input int dly, input int stall_at,
                          input int ill_at, input int start_at, input int rst_at);
    int n0;
    rd_log.delete();
    done_cnt = 0;
    hw = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("arm_busy", 32'(m_busy), 32'd1);
    chk("arm_sig", 32'(m_sig), 32'd0);
    step();
    chk("fetch_rd_en", 32'(m_rd_en), 32'd1);
    chk("fetch_addr0", 32'(m_addr), 32'd0);
    step();
    chk("latch_sig", 32'(m_sig), 32'd0);
    step();
    chk("lat4_sig", 32'(m_sig), 32'd1);
    for (int b = 0; b < 3 * n; b++) begin
      if (b > 0) wait_sig(2'd1, "send_sig");
      chk($sformatf("byte%0d", b), 32'(m_data), 32'(exp_q[b]));
      if (b == rst_at) begin
        #3 reset = 1'b1;
        #1;
        chk("rst_sig", 32'(m_sig), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        hw = 2'd0;
        step();
        reset = 1'b0;
        step();
        return;
      end
      if (b == stall_at) begin
        n0 = rd_log.size();
        for (int k = 0; k < 50; k++) begin
          step();
          chk("stall_sig", 32'(m_sig), 32'd1);
          chk("stall_data", 32'(m_data), 32'(exp_q[b]));
        end
        chk("stall_no_rd", 32'(rd_log.size()), 32'(n0));
      end
      if (b == ill_at) begin
        hw = 2'd3;
        for (int k = 0; k < 10; k++) begin
          step();
          chk("ill3_sig", 32'(m_sig), 32'd1);
          chk("ill3_data", 32'(m_data), 32'(exp_q[b]));
        end
      end
      pause(dly);
      hw = 2'd2;
      wait_sig(2'd0, "ack_sig");
      chk("ack_hold", 32'(m_data), 32'(exp_q[b]));
      if (b == ill_at) begin
        hw = 2'd0;
        for (int k = 0; k < 10; k++) begin
          step();
          chk("ill0_sig", 32'(m_sig), 32'd0);
          chk("ill0_data", 32'(m_data), 32'(exp_q[b]));
        end
      end
      if (b == start_at) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(m_busy), 32'd1);
      end
      pause(dly);
      hw = 2'd1;
    end
    wait_sig(2'd2, "done_sig");
    chk("done_busy", 32'(m_busy), 32'd1);
    chk("rd_count", 32'(rd_log.size()), 32'(n));
    for (int i = 0; i < rd_log.size() && i < n; i++)
      chk($sformatf("rd_addr%0d", i), 32'(rd_log[i]), 32'(i));
    pause(dly);
    hw = 2'd3;
    step();
    chk("done_pulse", 32'(m_done), 32'd1);
    chk("done_busy0", 32'(m_busy), 32'd0);
    chk("done_sig0", 32'(m_sig), 32'd0);
    step();
    chk("done_fall", 32'(m_done), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    hw = 2'd0;
    step();
  endtask

  initial begin
    ram_a[0] = 24'hA1B2C3;
    ram_a[1] = 24'h0D0E0F;
    for (int i = 0; i < 32; i++) ram_b[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h55};

    #2;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_sig", 32'(m_sig), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_rd_en", 32'(m_rd_en), 32'd0);
      chk("rst_addr", 32'(m_addr), 32'd0);
    end
    sel = 1'b0;
    step();
    reset = 1'b0;
    step();

    // 2-record DUT: basic, stall/illegal/stray start, reset abort, restart
    build_exp(2);
    run_xfer(2, 2, -1, -1, -1, -1);
    run_xfer(2, 2, 1, 0, 2, -1);
    run_xfer(2, -1, -1, -1, -1, 5);
    run_xfer(2, -1, -1, -1, -1, -1);
    ram_a[0] = $urandom;
    ram_a[1] = $urandom;
    build_exp(2);
    run_xfer(2, -1, -1, -1, -1, -1);

    // 32-record DUT: patterned contents, then random contents
    sel = 1'b1;
    step();
    build_exp(32);
    run_xfer(32, -1, -1, -1, -1, -1);
    for (int i = 0; i < 32; i++) ram_b[i] = $urandom;
    build_exp(32);
    run_xfer(32, -1, -1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
